// File: rtl/uart_tx_frame_engine.sv
// UART transmit engine: start bit, DATA_W data bits LSB first, optional parity, 1/2 stop bits.
// Define UART_TX_BREAK_EN to add break_req and a BREAK state that holds the line low.
module uart_tx_frame_engine #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BREAK_BITS = 13
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              baud_tick,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
`ifdef UART_TX_BREAK_EN
  input  logic              break_req,
`endif
  output logic              baud_clr,
  output logic              tx_out,
  output logic              busy,
  output logic              tx_done
);

  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  if ((DATA_W < 5) || (DATA_W > 9) || (BREAK_BITS == 0)) begin : gen_param_check
    $error("uart_tx_frame_engine: DATA_W must be 5..9 and BREAK_BITS nonzero");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
`ifdef UART_TX_BREAK_EN
    StBreak,
`endif
    StStop
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic              stop_cnt_q;
  logic              pbit_q;
  logic              par_en_q;
  logic              two_stop_q;

`ifdef UART_TX_BREAK_EN
  localparam int unsigned BrkW = $clog2(BREAK_BITS + 1);
  localparam logic [BrkW-1:0] LastBrk = BrkW'(BREAK_BITS - 1);
  logic [BrkW-1:0] brk_cnt_q;
`endif

  // tx_out is loaded alongside the state so it always carries the new state's bit.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      pbit_q     <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      tx_out     <= 1'b1;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      baud_clr   <= 1'b0;
      tx_done    <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_cnt_q  <= '0;
`endif
    end else begin
      baud_clr <= 1'b0;
      tx_done  <= 1'b0;
      case (state_q)
        StIdle: begin
`ifdef UART_TX_BREAK_EN
          if (break_req) begin
            state_q    <= StBreak;
            brk_cnt_q  <= '0;
            two_stop_q <= 1'b0;
            baud_clr   <= 1'b1;
            tx_out     <= 1'b0;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
          end else
`endif
          if (tx_valid) begin
            state_q    <= StStart;
            shreg_q    <= tx_data;
            pbit_q     <= parity_mode[1] ? ~^tx_data : ^tx_data;
            par_en_q   <= ^parity_mode;
            two_stop_q <= two_stop;
            baud_clr   <= 1'b1;
            tx_out     <= 1'b0;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
          end
        end
        StStart: begin
          if (baud_tick) begin
            state_q   <= StData;
            bit_cnt_q <= '0;
            tx_out    <= shreg_q[0];
          end
        end
        StData: begin
          if (baud_tick) begin
            shreg_q <= shreg_q >> 1;
            if (bit_cnt_q == LastBit) begin
              bit_cnt_q <= '0;
              if (par_en_q) begin
                state_q <= StParity;
                tx_out  <= pbit_q;
              end else begin
                state_q <= StStop;
                tx_out  <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CntW'(1);
              tx_out    <= shreg_q[1];
            end
          end
        end
        StParity: begin
          if (baud_tick) begin
            state_q <= StStop;
            tx_out  <= 1'b1;
          end
        end
`ifdef UART_TX_BREAK_EN
        StBreak: begin
          if (baud_tick) begin
            if (brk_cnt_q == LastBrk) begin
              brk_cnt_q <= '0;
              state_q   <= StStop;
              tx_out    <= 1'b1;
            end else begin
              brk_cnt_q <= brk_cnt_q + BrkW'(1);
            end
          end
        end
`endif
        StStop: begin
          if (baud_tick) begin
            if (two_stop_q && !stop_cnt_q) begin
              stop_cnt_q <= 1'b1;
            end else begin
              stop_cnt_q <= 1'b0;
              state_q    <= StIdle;
              tx_out     <= 1'b1;
              tx_ready   <= 1'b1;
              busy       <= 1'b0;
              tx_done    <= 1'b1;
            end
          end
        end
        default: begin
          state_q  <= StIdle;
          tx_out   <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Scoreboard bench for uart_tx_frame_engine: an 8-bit and a 5-bit instance, each with its own
// 4-clk baud generator that restarts on baud_clr.
module tb_uart_tx_frame_engine;

  logic       clk = 1'b0;
  logic       nrst;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       break_req;
  logic       baud_clr;
  logic       tx_out;
  logic       busy;
  logic       tx_done;

  logic       tick5;
  logic [4:0] data5;
  logic       valid5;
  logic       ready5;
  logic [1:0] mode5 = 2'b00;
  logic       ts5 = 1'b0;
  logic       brk5 = 1'b0;
  logic       clr5;
  logic       out5;
  logic       busy5;
  logic       done5;

  int n_checks = 0;
  int n_pass   = 0;
  int clr_cnt  = 0;
  logic exp_q[$];
  logic exp5_q[$];

  always #5 clk = ~clk;

  uart_tx_frame_engine #(.DATA_W(8), .BREAK_BITS(13)) u_dut (
    .clk(clk), .nrst(nrst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .parity_mode(parity_mode), .two_stop(two_stop),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .baud_clr(baud_clr), .tx_out(tx_out), .busy(busy), .tx_done(tx_done)
  );

  uart_tx_frame_engine #(.DATA_W(5), .BREAK_BITS(13)) u_dut5 (
    .clk(clk), .nrst(nrst), .baud_tick(tick5), .tx_data(data5), .tx_valid(valid5),
    .tx_ready(ready5), .parity_mode(mode5), .two_stop(ts5),
`ifdef UART_TX_BREAK_EN
    .break_req(brk5),
`endif
    .baud_clr(clr5), .tx_out(out5), .busy(busy5), .tx_done(done5)
  );

  logic [1:0] bcnt = 2'd0;
  logic [1:0] bcnt5 = 2'd0;
  always @(posedge clk) begin
    bcnt  <= (baud_clr || bcnt == 2'd3) ? 2'd0 : bcnt + 2'd1;
    bcnt5 <= (clr5 || bcnt5 == 2'd3) ? 2'd0 : bcnt5 + 2'd1;
    if (baud_clr) clr_cnt <= clr_cnt + 1;
  end
  assign baud_tick = (bcnt == 2'd3) && !baud_clr;
  assign tick5     = (bcnt5 == 2'd3) && !clr5;

  task automatic push_frame(input logic [7:0] d, input logic [1:0] m, input logic ts);
    int ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (m == 2'b01) exp_q.push_back((ones % 2) == 1);
    if (m == 2'b10) exp_q.push_back((ones % 2) == 0);
    exp_q.push_back(1'b1);
    if (ts) exp_q.push_back(1'b1);
  endtask

  task automatic drive_accept(input string name, input logic [7:0] d, input logic [1:0] m,
                              input logic ts, input logic keep);
    bit got = 0;
    @(negedge clk);
    tx_data = d; parity_mode = m; two_stop = ts; tx_valid = 1'b1;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (baud_clr) got = 1;
    end
    n_checks++;
    if (!got) $display("FAIL %s accept: baud_clr=0 required 1 within 10 clks", name);
    else n_pass++;
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic check_frame(input string name, input int exp_ticks);
    int ticks = 0;
    bit done = 0;
    logic e;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (tx_done) done = 1;
      else if (baud_tick && busy) begin
        ticks++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL %s extra bit: tx_out=%b required none", name, tx_out);
        else begin
          e = exp_q.pop_front();
          if (tx_out !== e) $display("FAIL %s bit%0d: tx_out=%b required %b", name, ticks, tx_out, e);
          else n_pass++;
        end
        n_checks++;
        if (tx_ready !== 1'b0) $display("FAIL %s ready: tx_ready=%b required 0", name, tx_ready);
        else n_pass++;
      end
    end
    n_checks++;
    if (!done) $display("FAIL %s done: tx_done never seen, required within 300 clks", name);
    else n_pass++;
    n_checks++;
    if (ticks != exp_ticks) $display("FAIL %s length: ticks=%0d required %0d", name, ticks, exp_ticks);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL %s leftover: %0d bits required 0", name, exp_q.size());
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset;
    n_checks++;
    if ({tx_out, tx_ready, busy, baud_clr, tx_done} !== 5'b11000)
      $display("FAIL reset: out/ready/busy/clr/done=%b required 11000",
               {tx_out, tx_ready, busy, baud_clr, tx_done});
    else n_pass++;
    n_checks++;
    if ({out5, ready5, busy5} !== 3'b110)
      $display("FAIL reset5: out/ready/busy=%b required 110", {out5, ready5, busy5});
    else n_pass++;
  endtask

  task automatic test_plain;
    drive_accept("plain", 8'hA5, 2'b00, 1'b0, 1'b0);
    push_frame(8'hA5, 2'b00, 1'b0);
    check_frame("plain_a5", 10);
    drive_accept("mode11", 8'h5A, 2'b11, 1'b0, 1'b0);
    push_frame(8'h5A, 2'b00, 1'b0);
    check_frame("mode11_5a", 10);
  endtask

  task automatic test_parity;
    drive_accept("even", 8'hA5, 2'b01, 1'b0, 1'b0);
    push_frame(8'hA5, 2'b01, 1'b0);
    check_frame("even_a5", 11);
    drive_accept("odd", 8'hA5, 2'b10, 1'b0, 1'b0);
    push_frame(8'hA5, 2'b10, 1'b0);
    check_frame("odd_a5", 11);
  endtask

  task automatic test_two_stop;
    drive_accept("two_stop", 8'h07, 2'b10, 1'b1, 1'b0);
    push_frame(8'h07, 2'b10, 1'b1);
    check_frame("two_stop_07", 12);
  endtask

  task automatic test_width5;
    bit got = 0;
    bit done = 0;
    int ticks = 0;
    logic e;
    @(negedge clk);
    data5 = 5'h1F; valid5 = 1'b1;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (clr5) got = 1;
    end
    valid5 = 1'b0;
    n_checks++;
    if (!got) $display("FAIL w5 accept: baud_clr=0 required 1");
    else n_pass++;
    exp5_q.push_back(1'b0);
    for (int i = 0; i < 5; i++) exp5_q.push_back(1'b1);
    exp5_q.push_back(1'b1);
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (done5) done = 1;
      else if (tick5 && busy5) begin
        ticks++;
        e = (exp5_q.size() != 0) ? exp5_q.pop_front() : 1'bx;
        n_checks++;
        if (out5 !== e) $display("FAIL w5 bit%0d: tx_out=%b required %b", ticks, out5, e);
        else n_pass++;
      end
    end
    n_checks++;
    if (!done || ticks != 7)
      $display("FAIL w5 length: done=%0d ticks=%0d required 1 and 7", done, ticks);
    else n_pass++;
    exp5_q.delete();
  endtask

  task automatic test_back_to_back;
    int c0 = clr_cnt;
    drive_accept("b2b", 8'hA5, 2'b01, 1'b0, 1'b1);
    // Config changed mid-frame must only affect the next frame.
    tx_data = 8'h3C; parity_mode = 2'b10; two_stop = 1'b0;
    push_frame(8'hA5, 2'b01, 1'b0);
    check_frame("b2b_1", 11);
    n_checks++;
    if (tx_ready !== 1'b1) $display("FAIL b2b ready_at_done: tx_ready=%b required 1", tx_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (baud_clr !== 1'b1) $display("FAIL b2b second_accept: baud_clr=%b required 1", baud_clr);
    else n_pass++;
    tx_valid = 1'b0;
    push_frame(8'h3C, 2'b10, 1'b0);
    check_frame("b2b_2", 11);
    repeat (3) @(negedge clk);
    n_checks++;
    if (clr_cnt - c0 != 2) $display("FAIL b2b clr_count: pulses=%0d required 2", clr_cnt - c0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    int ticks = 0;
    logic e;
    drive_accept("rst_mid", 8'hA5, 2'b00, 1'b0, 1'b0);
    push_frame(8'hA5, 2'b00, 1'b0);
    for (int c = 0; c < 100 && ticks < 4; c++) begin
      @(negedge clk);
      if (baud_tick && busy) begin
        ticks++;
        e = exp_q.pop_front();
        n_checks++;
        if (tx_out !== e) $display("FAIL rst_mid bit%0d: tx_out=%b required %b", ticks, tx_out, e);
        else n_pass++;
      end
    end
    @(posedge clk);
    #1 nrst = 1'b0;
    #1;
    n_checks++;
    if ({tx_out, tx_ready, busy} !== 3'b110)
      $display("FAIL rst_mid abort: out/ready/busy=%b required 110", {tx_out, tx_ready, busy});
    else n_pass++;
    exp_q.delete();
    @(negedge clk);
    nrst = 1'b1;
    drive_accept("after_rst", 8'h3C, 2'b01, 1'b1, 1'b0);
    push_frame(8'h3C, 2'b01, 1'b1);
    check_frame("after_rst_3c", 12);
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break;
    @(negedge clk);
    break_req = 1'b1;
    drive_accept("break", 8'h55, 2'b00, 1'b1, 1'b1);
    break_req = 1'b0;
    for (int i = 0; i < 13; i++) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    check_frame("break", 14);
    @(negedge clk);
    n_checks++;
    if (baud_clr !== 1'b1) $display("FAIL brk data_accept: baud_clr=%b required 1", baud_clr);
    else n_pass++;
    tx_valid = 1'b0;
    push_frame(8'h55, 2'b00, 1'b1);
    check_frame("brk_data_55", 11);
  endtask
`endif

  initial begin
    nrst = 1'b0; tx_data = '0; tx_valid = 1'b0; parity_mode = 2'b00; two_stop = 1'b0;
    break_req = 1'b0; data5 = '0; valid5 = 1'b0;
    #12;
    test_reset;
    @(negedge clk);
    nrst = 1'b1;
    test_plain;
    test_parity;
    test_two_stop;
    test_width5;
    test_back_to_back;
    test_reset_mid_frame;
`ifdef UART_TX_BREAK_EN
    test_break;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
